poly_ram_reader: RTL and testbench
==================================

// Module: poly_ram_reader
// PURPOSE
//   Read-side streamer for the dual-port polynomial BRAM. On start it reads COUNT consecutive
//   16-bit coefficients from one BRAM port, beginning at BASE and wrapping modulo LENGTH.
//   It presents them on a valid/ready stream with a last flag. NTT/packing stages use it
//   to drain polynomials; it absorbs the BRAM's 1-cycle read latency and stream backpressure.
// PARAMETERS
//   LENGTH  2048  BRAM depth in words; ADDR_W = $clog2(LENGTH); must be a power of two
// PORTS
//   clk        in   1        single clock; all state on posedge
//   rst        in   1        asynchronous, active-high reset
//   start      in   1        1-cycle request; sampled only in IDLE
//   base_addr  in   ADDR_W   first word address; sampled with start
//   count      in   ADDR_W+1 words to read, 0..LENGTH; sampled with start
//   busy       out  1        high in RUN, DRAIN and DONE
//   done       out  1        1-cycle pulse after the last word is accepted
//   ram_en     out  1        BRAM port enable; asserted only to issue a read
//   ram_we     out  1        tied 0
//   ram_addr   out  ADDR_W   BRAM port address
//   ram_dout   in   16       BRAM read data; valid exactly 1 cycle after ram_en
//   m_data     out  16       stream data
//   m_valid    out  1        stream valid
//   m_last     out  1        high with the final word of the request
//   m_ready    in   1        stream ready; a word transfers when m_valid & m_ready
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, ram_en, ram_we, m_valid and m_last are 0;
//     ram_addr=0, m_data=0; counters cleared and buffer emptied.
//   Reset mid-request: drops every in-flight read and buffered word; no done pulse.
//   FSM:
//     IDLE  -> RUN on start with count!=0.
//     IDLE  -> DONE on start with count==0 (no reads, no stream beats).
//     RUN   -> DRAIN on the cycle the count-th read is issued.
//     DRAIN -> DONE when the final word (m_last) is accepted.
//     DONE  -> IDLE after 1 cycle; done=1 only in DONE.
//   start outside IDLE is ignored; base_addr and count are never re-sampled mid-request.
//   Issue: ram_addr = (base_addr + issued) mod LENGTH, natural ADDR_W wrap.
//     issued increments on every ram_en.
//   Output buffer: 2-entry FIFO. inflight = reads issued last cycle (0/1).
//     In RUN, ram_en=1 iff occ + inflight - pop < 2, where pop = m_valid & m_ready this cycle.
//     This guarantees no overflow and keeps a 1 word/cycle sustained rate with m_ready=1.
//   Capture: ram_dout is written into the FIFO on the clock edge ending the cycle after ram_en.
//     m_valid = (occ != 0); m_data = FIFO head.
//   m_last=1 iff the head word is word number count-1 (0-based). It is never set on other words.
//   Latency: start in cycle 0 -> ram_en (addr=base) in cycle 1 -> m_valid in cycle 3.
//   Once asserted, m_valid stays high and m_data stays stable until accepted (AXI-stream rules).
//   Simultaneous capture and pop with occ=2: legal; occ stays 2 and order is preserved.
//   count==LENGTH reads every word exactly once; the wrap returns to base with no duplicates.
// TESTING
//   1. base=0, count=4, RAM[i]=i+0x100, m_ready=1:
//      m_data 0x100..0x103 in cycles 3..6; m_last in cycle 6; done in cycle 7; idle in cycle 8.
//   2. base=2046, count=4, LENGTH=2048: ram_addr 2046, 2047, 0, 1; data in the same order.
//   3. count=8, m_ready toggles 1,0,0,1,...:
//      no word lost or duplicated; m_data stable while stalled; ram_en never makes occ exceed 2.
//   4. count=0: no ram_en and no m_valid; done pulses 1 cycle after start.
//      A second start during busy is ignored.
//   5. count=2048, m_ready=1: exactly 2048 beats in 2048 consecutive cycles; m_last only on the last.
//   6. Assert rst while 3 words are outstanding:
//      all outputs go to 0 that cycle; no done; a new start=1, count=1 completes normally.

Source files
------------

// File: rtl/poly_ram_reader.sv
// Streams COUNT words from one port of the polynomial BRAM, starting at BASE and wrapping
// modulo LENGTH, onto a valid/ready stream with a last flag.
module poly_ram_reader #(
  parameter  int LENGTH = 2048,
  localparam int ADDR_W = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_dout,
  output logic [15:0]       m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_W:0] ONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   popped_q, popped_d;
  logic              inflight_q;
  logic [1:0]        occ_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [15:0]       fifo_q [2];

  logic              pop;
  logic              can_issue;
  logic [2:0]        fill;
  logic [ADDR_W:0]   last_idx;

  assign last_idx = count_q - ONE;
  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = m_valid ? fifo_q[rd_ptr_q] : 16'h0000;
  // The head word's index is the number of words already accepted.
  assign m_last   = m_valid && (popped_q == last_idx);
  assign pop      = m_valid & m_ready;

  // A read issued now lands one cycle after the in-flight one, so reserve both slots.
  assign fill      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign can_issue = (fill < 3'd2);

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign ram_we   = 1'b0;
  assign ram_addr = (state_q == S_RUN) ? base_q + issued_q[ADDR_W-1:0] : '0;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    issued_d = issued_q;
    popped_d = pop ? popped_q + ONE : popped_q;
    ram_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          count_d  = count;
          issued_d = '0;
          popped_d = '0;
          state_d  = (count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (can_issue) begin
          ram_en   = 1'b1;
          issued_d = issued_q + ONE;
          if (issued_q == last_idx) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= ram_en;
      occ_q      <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop)        rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: FIFO storage is not reset; occupancy gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= ram_dout;
  end

endmodule

// File: tb/tb_poly_ram_reader.sv
// Directed bench for poly_ram_reader: BRAM model, scoreboard of expected beats and
// a negedge monitor that checks every accepted word, stall stability and fill level.
module tb_poly_ram_reader;

  localparam int LENGTH = 2048;
  localparam int AW     = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy, done, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_dout;
  logic [15:0]   m_data;
  logic          m_valid, m_last, m_ready;

  int tests = 0;
  int fails = 0;

  logic [16:0] sb [$];
  logic [15:0] mem [LENGTH];

  int          en_cnt = 0, pop_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = 16'h0;

  poly_ram_reader #(.LENGTH(LENGTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on every transfer, stall stability, occupancy bound.
  always @(negedge clk) begin
    if (rst) begin
      en_cnt     <= 0;
      pop_cnt    <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {16'd0, m_data}, {16'd0, prev_data});
      end
      if (busy) check("outstanding_le_2", {31'd0, (en_cnt - pop_cnt) <= 2}, 32'd1);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {16'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          check("beat_data", {16'd0, m_data}, {16'd0, e[15:0]});
          check("beat_last", {31'd0, m_last}, {31'd0, e[16]});
        end
      end
      en_cnt     <= en_cnt + (ram_en ? 1 : 0);
      pop_cnt    <= pop_cnt + ((m_valid && m_ready) ? 1 : 0);
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [AW-1:0] b, input int c);
    for (int i = 0; i < c; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      sb.push_back({(i == c - 1), 16'(16'h0100 + 16'(a))});
    end
  endtask

  task automatic issue_start(input logic [AW-1:0] b, input int c);
    start     = 1'b1;
    base_addr = b;
    count     = (AW+1)'(c);
  endtask

  // Runs until done is seen (bounded); mode 1 gives m_ready = 1,0,0 repeating.
  task automatic wait_done(input int budget, input int mode);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      next_cycle();
      start   = 1'b0;
      m_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    next_cycle();
    m_ready = 1'b1;
    check("scoreboard_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_c, last_c, beats, en_before;
    logic fin;
    for (int i = 0; i < LENGTH; i++) mem[i] = 16'(16'h0100 + i);
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {21'd0, ram_addr}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_m_data", {16'd0, m_data}, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // 1: base 0, count 4, cycle-exact latency
    issue_start(11'd0, 4);
    push_req(11'd0, 4);
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", c), {31'd0, m_valid}, {31'd0, c >= 3 && c <= 6});
      check($sformatf("t1_last_c%0d", c), {31'd0, m_last}, {31'd0, c == 6});
      check($sformatf("t1_done_c%0d", c), {31'd0, done}, {31'd0, c == 7});
      check($sformatf("t1_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 7});
      check($sformatf("t1_ram_en_c%0d", c), {31'd0, ram_en}, {31'd0, c <= 4});
      if (c <= 4) check($sformatf("t1_addr_c%0d", c), {21'd0, ram_addr}, 32'(c - 1));
    end
    check("t1_sb_empty", sb.size(), 32'd0);
    next_cycle();

    // 2: wrap at the top of the address space
    issue_start(11'd2046, 4);
    push_req(11'd2046, 4);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      check($sformatf("t2_ram_en_c%0d", c), {31'd0, ram_en}, 32'd1);
      check($sformatf("t2_addr_c%0d", c), {21'd0, ram_addr}, (2046 + c - 1) % LENGTH);
    end
    wait_done(20, 0);

    // 3: backpressure
    issue_start(11'd5, 8);
    push_req(11'd5, 8);
    wait_done(100, 1);

    // 4: zero-length request plus ignored restart
    en_before = en_cnt;
    issue_start(11'd7, 0);
    next_cycle();
    issue_start(11'd3, 4);
    @(negedge clk);
    check("t4_done_c1", {31'd0, done}, 32'd1);
    check("t4_busy_c1", {31'd0, busy}, 32'd1);
    check("t4_ram_en_c1", {31'd0, ram_en}, 32'd0);
    check("t4_valid_c1", {31'd0, m_valid}, 32'd0);
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("t4_done_c2", {31'd0, done}, 32'd0);
    check("t4_busy_c2", {31'd0, busy}, 32'd0);
    repeat (3) next_cycle();
    @(negedge clk);
    check("t4_no_reads", en_cnt, en_before);
    check("t4_no_valid", {31'd0, m_valid}, 32'd0);
    next_cycle();

    // 5: full-length request at full rate
    issue_start(11'd100, LENGTH);
    push_req(11'd100, LENGTH);
    first_c = -1; last_c = -1; beats = 0; fin = 1'b0;
    for (int c = 1; c <= LENGTH + 20 && !fin; c++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      if (m_valid) begin
        beats++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (done) fin = 1'b1;
    end
    check("t5_done_seen", {31'd0, fin}, 32'd1);
    check("t5_beats", beats, LENGTH);
    check("t5_span", last_c - first_c, LENGTH - 1);
    check("t5_first_cycle", first_c, 3);
    check("t5_sb_empty", sb.size(), 32'd0);
    next_cycle();

    // 6: reset mid-request, then a normal one-word request
    m_ready = 1'b0;
    issue_start(11'd0, 8);
    repeat (3) begin
      next_cycle();
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_ram_en", {31'd0, ram_en}, 32'd0);
    check("t6_ram_addr", {21'd0, ram_addr}, 32'd0);
    check("t6_m_valid", {31'd0, m_valid}, 32'd0);
    check("t6_m_last", {31'd0, m_last}, 32'd0);
    check("t6_m_data", {16'd0, m_data}, 32'd0);
    next_cycle();
    rst = 1'b0;
    m_ready = 1'b1;
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("t6_no_done_%0d", c), {31'd0, done}, 32'd0);
    end
    next_cycle();
    issue_start(11'd9, 1);
    push_req(11'd9, 1);
    wait_done(20, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
